// File: rtl/tone_command_decoder_pkg.sv
// rtl/tone_command_decoder_pkg.sv - shared command codes, FSM states and tone decode helper
package tone_command_decoder_pkg;

    localparam int NUM_CH = 5;

    localparam logic [2:0] CMD_NONE       = 3'd0;
    localparam logic [2:0] CMD_STOP       = 3'd1;
    localparam logic [2:0] CMD_FORWARD    = 3'd2;
    localparam logic [2:0] CMD_VEER_LEFT  = 3'd3;
    localparam logic [2:0] CMD_VEER_RIGHT = 3'd4;
    localparam logic [2:0] CMD_REVERSE    = 3'd5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        CONFIRMED = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] idx;
        logic       multi;
    } tone_sel_t;

    // idx is 1-based channel number when exactly one bit is set, else CMD_NONE
    function automatic tone_sel_t decode_tones(input logic [NUM_CH-1:0] vec);
        tone_sel_t   sel;
        int unsigned ones;
        sel  = '0;
        ones = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (vec[i]) begin
                ones++;
                sel.idx = 3'(i + 1);
            end
        end
        if (ones != 1) begin
            sel.idx = CMD_NONE;
        end
        sel.multi = (ones > 1);
        return sel;
    endfunction

endpackage

// File: rtl/tone_command_decoder_if.sv
// rtl/tone_command_decoder_if.sv - comparator inputs and junction command outputs
interface tone_command_decoder_if;
    import tone_command_decoder_pkg::*;

    logic              bp1;
    logic              bp2;
    logic              bp3;
    logic              bp4;
    logic              bp5;
    logic [2:0]        cmd_code;
    logic              cmd_valid;
    logic              tone_active;
    logic              multi_tone_err;
    logic [NUM_CH-1:0] present;

    modport master (
        output bp1, bp2, bp3, bp4, bp5,
        input  cmd_code, cmd_valid, tone_active, multi_tone_err, present
    );

    modport slave (
        input  bp1, bp2, bp3, bp4, bp5,
        output cmd_code, cmd_valid, tone_active, multi_tone_err, present
    );

endinterface

// File: rtl/tone_channel_detector.sv
// rtl/tone_channel_detector.sv - per-channel synchroniser, edge counter and presence flag
module tone_channel_detector #(
    parameter int MIN_EDGES  = 20,
    parameter int EDGE_CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bp_in,
    input  logic win_end,
    output logic present_nxt,
    output logic present
);

    localparam logic [EDGE_CNT_W:0] MIN_EDGES_W = (EDGE_CNT_W + 1)'(MIN_EDGES);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  sync3_q, sync3_d;
    logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  present_q, present_d;
    logic                  edge_det;
    logic [EDGE_CNT_W:0]   closing_sum;

    assign edge_det    = sync2_q & ~sync3_q;
    // An edge seen in the win_end cycle still belongs to the closing window
    assign closing_sum = {1'b0, cnt_q} + (EDGE_CNT_W + 1)'(edge_det);
    assign present_nxt = (closing_sum >= MIN_EDGES_W);
    assign present     = present_q;

    always_comb begin
        sync1_d   = bp_in;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        cnt_d     = cnt_q;
        present_d = present_q;
        if (win_end) begin
            present_d = present_nxt;
            cnt_d     = '0;
        end else if (edge_det && (cnt_q != {EDGE_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + EDGE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            cnt_q     <= '0;
            present_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            cnt_q     <= cnt_d;
            present_q <= present_d;
        end
    end

endmodule

// File: rtl/tone_command_decoder.sv
// rtl/tone_command_decoder.sv - window timing, single-tone selection and confirm/release FSM
module tone_command_decoder
    import tone_command_decoder_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 500_000,
    parameter int MIN_EDGES       = 20,
    parameter int EDGE_CNT_W      = 8,
    parameter int CONFIRM_WINDOWS = 3,
    parameter int RELEASE_WINDOWS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tone_command_decoder_if.slave  bus
);

    localparam int         WIN_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [2:0] CONFIRM_N = 3'(CONFIRM_WINDOWS);
    localparam logic [2:0] RELEASE_N = 3'(RELEASE_WINDOWS);

    if (CONFIRM_WINDOWS < 1 || CONFIRM_WINDOWS > 7 ||
        RELEASE_WINDOWS < 1 || RELEASE_WINDOWS > 7) begin : g_param_check
        $error("CONFIRM_WINDOWS and RELEASE_WINDOWS must be in 1..7");
    end

    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic              win_end;
    logic [NUM_CH-1:0] bp_raw;
    logic [NUM_CH-1:0] present_nxt;
    logic [NUM_CH-1:0] present;
    tone_sel_t         sel;

    state_e            state_q, state_d;
    logic [2:0]        cand_q, cand_d;
    logic [2:0]        hits_q, hits_d;
    logic [2:0]        misses_q, misses_d;
    logic [2:0]        cmd_code_q, cmd_code_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              multi_err_q, multi_err_d;
    logic              do_confirm;
    logic [2:0]        confirm_code;

    assign bp_raw  = {bus.bp5, bus.bp4, bus.bp3, bus.bp2, bus.bp1};
    assign win_end = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel_detector #(
            .MIN_EDGES  (MIN_EDGES),
            .EDGE_CNT_W (EDGE_CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .bp_in       (bp_raw[i]),
            .win_end     (win_end),
            .present_nxt (present_nxt[i]),
            .present     (present[i])
        );
    end

    // Deciding on the closing vector lets present, cmd_code and the strobes all update together
    assign sel = decode_tones(present_nxt);

    always_comb begin
        win_cnt_d    = win_end ? '0 : win_cnt_q + WIN_W'(1);
        state_d      = state_q;
        cand_d       = cand_q;
        hits_d       = hits_q;
        misses_d     = misses_q;
        cmd_code_d   = cmd_code_q;
        cmd_valid_d  = 1'b0;
        multi_err_d  = 1'b0;
        do_confirm   = 1'b0;
        confirm_code = cand_q;
        if (win_end) begin
            multi_err_d = sel.multi;
            case (state_q)
                IDLE: begin
                    if (sel.idx != CMD_NONE) begin
                        if (CONFIRM_WINDOWS == 1) begin
                            do_confirm   = 1'b1;
                            confirm_code = sel.idx;
                        end else begin
                            cand_d  = sel.idx;
                            hits_d  = 3'd1;
                            state_d = CANDIDATE;
                        end
                    end
                end
                CANDIDATE: begin
                    if (sel.idx == CMD_NONE) begin
                        state_d = IDLE;
                    end else if (sel.idx == cand_q) begin
                        if (hits_q + 3'd1 == CONFIRM_N) begin
                            do_confirm = 1'b1;
                        end else begin
                            hits_d = hits_q + 3'd1;
                        end
                    end else begin
                        cand_d = sel.idx;
                        hits_d = 3'd1;
                    end
                end
                CONFIRMED: begin
                    if (sel.idx == cmd_code_q) begin
                        misses_d = '0;
                    end else if (misses_q + 3'd1 == RELEASE_N) begin
                        misses_d = '0;
                        state_d  = IDLE;
                    end else begin
                        misses_d = misses_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (do_confirm) begin
                cmd_code_d  = confirm_code;
                cmd_valid_d = 1'b1;
                hits_d      = '0;
                misses_d    = '0;
                state_d     = CONFIRMED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q   <= '0;
            state_q     <= IDLE;
            cand_q      <= CMD_NONE;
            hits_q      <= '0;
            misses_q    <= '0;
            cmd_code_q  <= CMD_NONE;
            cmd_valid_q <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            cmd_code_q  <= cmd_code_d;
            cmd_valid_q <= cmd_valid_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign bus.cmd_code       = cmd_code_q;
    assign bus.cmd_valid      = cmd_valid_q;
    assign bus.tone_active    = (state_q == CONFIRMED);
    assign bus.multi_tone_err = multi_err_q;
    assign bus.present        = present;

endmodule
